// File: rtl/l1_request_arbiter_pkg.sv
// Shared L1 configuration constants and request types.
// Port index of every L1 client equals its L1 ID below.
package l1_request_arbiter_pkg;

    localparam int L1_CONNECTIONS     = 4;
    localparam int L1_DCACHE_ID       = 0;
    localparam int L1_DMMU_ID         = 1;
    localparam int L1_ICACHE_ID       = 2;
    localparam int L1_IMMU_ID         = 3;
    localparam int MAX_INFLIGHT_COUNT = 4;
    localparam int L1_ID_W            = $clog2(L1_CONNECTIONS);

    typedef logic [L1_ID_W-1:0] l1_id_t;

    // len holds the burst length minus one, in words
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        rnw;
        logic [4:0]  len;
    } l1_request_t;

endpackage

// File: rtl/l1_request_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first eligible port after last_grant.
// Purely combinational so other arbiters can share it.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Scan ports last_grant+1 .. last_grant+N (mod N), keep the first hit
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(last_grant) + k) % N);
            if (!w_found && eligible[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l1_request_arbiter.sv
// Merges the L1 requesters onto one registered memory request channel
// with a read-outstanding limit, and routes read beats back by ID.
module l1_request_arbiter
    import l1_request_arbiter_pkg::*;
#(
    parameter int NUM_PORTS             = L1_CONNECTIONS,
    parameter int ID_W                  = $clog2(NUM_PORTS),
    parameter int MAX_OUTSTANDING_READS = MAX_INFLIGHT_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] req_ready,
    input  l1_request_t          req [NUM_PORTS],
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output l1_request_t          mem_req,
    output logic [ID_W-1:0]      mem_req_id,
    input  logic                 mem_rd_valid,
    input  logic [31:0]          mem_rd_data,
    input  logic [ID_W-1:0]      mem_rd_id,
    input  logic                 mem_rd_last,
    output logic [NUM_PORTS-1:0] rd_valid,
    output logic [31:0]          rd_data,
    output logic                 rd_last
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING_READS) + 1;

    logic                 r_out_valid;
    l1_request_t          r_out_req;
    logic [ID_W-1:0]      r_out_id;
    logic [ID_W-1:0]      r_last_grant;
    logic [CNT_W-1:0]     r_rd_cnt;
    logic [NUM_PORTS-1:0] r_rd_valid;
    logic [31:0]          r_rd_data;
    logic                 r_rd_last;

    logic [NUM_PORTS-1:0] w_eligible;
    logic [NUM_PORTS-1:0] w_grant;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_can_load;
    logic                 w_accept;
    logic                 w_acc_read;
    logic                 w_rd_done;
    logic                 w_rd_room;

    assign w_rd_room = (r_rd_cnt < CNT_W'(MAX_OUTSTANDING_READS));

    // Writes bypass the read limit; reads wait for room
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_eligible[i] = req_valid[i] & (~req[i].rnw | w_rd_room);
        end
    end

    rr_priority_picker #(
        .N  (NUM_PORTS),
        .IW (ID_W)
    ) u_picker (
        .eligible   (w_eligible),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    // Pass-through: a draining register may reload in the same cycle
    assign w_can_load = ~r_out_valid | mem_req_ready;
    assign req_ready  = w_grant & {NUM_PORTS{w_can_load & ~rst}};
    assign w_accept   = |req_ready;
    assign w_acc_read = w_accept & req[w_grant_idx].rnw;
    assign w_rd_done  = mem_rd_valid & mem_rd_last & (r_rd_cnt != '0);

    // Output register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_req    <= '0;
            r_out_id     <= '0;
            r_last_grant <= ID_W'(NUM_PORTS - 1);
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_req    <= req[w_grant_idx];
            r_out_id     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
        end else if (mem_req_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Outstanding-read counter; a stray last beat at zero is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
        end else if (w_acc_read && !w_rd_done) begin
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end else if (!w_acc_read && w_rd_done) begin
            r_rd_cnt <= r_rd_cnt - CNT_W'(1);
        end
    end

    // Register each read beat and steer it to its owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= mem_rd_valid ? (NUM_PORTS'(1) << mem_rd_id) : '0;
            r_rd_last  <= mem_rd_valid & mem_rd_last;
            if (mem_rd_valid) begin
                r_rd_data <= mem_rd_data;
            end
        end
    end

    // A last beat with nothing outstanding is a memory-side protocol bug
    a_no_rd_underflow : assert property (
        @(posedge clk) disable iff (rst)
        !(mem_rd_valid && mem_rd_last && r_rd_cnt == '0)
    );

    assign mem_req_valid = r_out_valid;
    assign mem_req       = r_out_req;
    assign mem_req_id    = r_out_id;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign rd_last       = r_rd_last;

endmodule
